// File: rtl/wb_regfile.sv
// rtl/wb_regfile.sv - Write-back select, R0..R7 register file with write-through bypass, retired-write counter
module wb_regfile #(
  parameter int DATA_W  = 8,
  parameter int INSTR_W = 19,
  parameter int CNT_W   = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [DATA_W-1:0]  wb_mem_data,
  input  logic [DATA_W-1:0]  wb_alu_out,
  input  logic [DATA_W-1:0]  wb_shift_out,
  input  logic [INSTR_W-1:0] wb_instruction,
  input  logic [1:0]         wb_reg_write_mux,
  input  logic [2:0]         rd_addr_a,
  input  logic [2:0]         rd_addr_b,
  output logic [DATA_W-1:0]  rd_data_a,
  output logic [DATA_W-1:0]  rd_data_b,
  output logic               wb_we,
  output logic [2:0]         wb_dest,
  output logic [DATA_W-1:0]  wb_data,
  output logic [CNT_W-1:0]   retire_cnt
);

  localparam int REG_N = 8;

  // Entry 0 is cleared on reset and never written, so it reads as zero.
  logic [DATA_W-1:0] regs [REG_N];

  logic unused_instr_bits;
  assign unused_instr_bits = ^{wb_instruction[INSTR_W-1:14], wb_instruction[10:0]};

  assign wb_dest = wb_instruction[13:11];

  always_comb begin
    wb_data = '0;
    case (wb_reg_write_mux)
      2'b01:   wb_data = wb_alu_out;
      2'b10:   wb_data = wb_shift_out;
      2'b11:   wb_data = wb_mem_data;
      default: wb_data = '0;
    endcase
  end

  assign wb_we = (wb_reg_write_mux != 2'b00) && (wb_dest != 3'd0);

  // Bypass is suppressed while reset is held so reads see the cleared file.
  always_comb begin
    rd_data_a = '0;
    if (rd_addr_a != 3'd0) begin
      if (reset && wb_we && (rd_addr_a == wb_dest))
        rd_data_a = wb_data;
      else
        rd_data_a = regs[rd_addr_a];
    end
  end

  always_comb begin
    rd_data_b = '0;
    if (rd_addr_b != 3'd0) begin
      if (reset && wb_we && (rd_addr_b == wb_dest))
        rd_data_b = wb_data;
      else
        rd_data_b = regs[rd_addr_b];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < REG_N; i++)
        regs[i] <= '0;
      retire_cnt <= '0;
    end else if (wb_we) begin
      regs[wb_dest] <= wb_data;
      retire_cnt    <= retire_cnt + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_wb_regfile.sv
// tb/tb_wb_regfile.sv - Directed scoreboard bench for wb_regfile
module tb_wb_regfile;

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  wb_mem_data, wb_alu_out, wb_shift_out;
  logic [18:0] wb_instruction;
  logic [1:0]  wb_reg_write_mux;
  logic [2:0]  rd_addr_a, rd_addr_b;
  logic [7:0]  rd_data_a, rd_data_b;
  logic        wb_we;
  logic [2:0]  wb_dest;
  logic [7:0]  wb_data;
  logic [15:0] retire_cnt;

  wb_regfile dut (
    .clk(clk), .reset(reset),
    .wb_mem_data(wb_mem_data), .wb_alu_out(wb_alu_out), .wb_shift_out(wb_shift_out),
    .wb_instruction(wb_instruction), .wb_reg_write_mux(wb_reg_write_mux),
    .rd_addr_a(rd_addr_a), .rd_addr_b(rd_addr_b),
    .rd_data_a(rd_data_a), .rd_data_b(rd_data_b),
    .wb_we(wb_we), .wb_dest(wb_dest), .wb_data(wb_data), .retire_cnt(retire_cnt)
  );

  always #5 clk = ~clk;

  typedef struct { string tag; logic [15:0] exp; } sb_t;
  sb_t sb_q[$];
  int pass_cnt = 0;
  int total_cnt = 0;

  logic [7:0]  ref_regs [8];
  logic [15:0] ref_cnt;
  logic [2:0]  cur_dest;

  function automatic logic [7:0] ref_sel();
    case (wb_reg_write_mux)
      2'b01:   return wb_alu_out;
      2'b10:   return wb_shift_out;
      2'b11:   return wb_mem_data;
      default: return 8'h00;
    endcase
  endfunction

  function automatic logic ref_we();
    return (wb_reg_write_mux != 2'b00) && (cur_dest != 3'd0);
  endfunction

  function automatic logic [7:0] ref_read(input logic [2:0] addr);
    if (addr == 3'd0) return 8'h00;
    if (reset && ref_we() && addr == cur_dest) return ref_sel();
    return ref_regs[addr];
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 8; i++) ref_regs[i] = 8'h00;
    ref_cnt = 16'h0000;
  endtask

  task automatic push(input string tag, input logic [15:0] exp);
    sb_t e;
    e.tag = tag;
    e.exp = exp;
    sb_q.push_back(e);
  endtask

  task automatic pop_check(input logic [15:0] obs);
    sb_t e;
    total_cnt++;
    if (sb_q.size() == 0) begin
      $error("FAIL sb_underflow: observed %h required an expected entry", obs);
      return;
    end
    e = sb_q.pop_front();
    assert (obs === e.exp) pass_cnt++;
    else $error("FAIL %s: observed %h expected %h", e.tag, obs, e.exp);
  endtask

  task automatic drive(input logic [1:0] mux, input logic [2:0] dest,
                       input logic [7:0] alu, input logic [7:0] shf, input logic [7:0] mem);
    logic [18:0] instr;
    instr = 19'($urandom);
    instr[13:11] = dest;
    wb_instruction   = instr;
    cur_dest         = dest;
    wb_reg_write_mux = mux;
    wb_alu_out       = alu;
    wb_shift_out     = shf;
    wb_mem_data      = mem;
  endtask

  task automatic bubble();
    drive(2'b00, 3'(($urandom % 7) + 1), 8'($urandom), 8'($urandom), 8'($urandom));
  endtask

  task automatic set_rd(input logic [2:0] a, input logic [2:0] b);
    rd_addr_a = a;
    rd_addr_b = b;
  endtask

  task automatic tick();
    logic       we;
    logic [7:0] d;
    logic [2:0] dst;
    we  = ref_we();
    d   = ref_sel();
    dst = cur_dest;
    @(posedge clk);
    if (reset && we) begin
      ref_regs[dst] = d;
      ref_cnt++;
    end
    #1;
  endtask

  task automatic write(input logic [2:0] dest, input logic [1:0] mux, input logic [7:0] val);
    drive(mux, dest, (mux == 2'b01) ? val : 8'($urandom),
                     (mux == 2'b10) ? val : 8'($urandom),
                     (mux == 2'b11) ? val : 8'($urandom));
    tick();
  endtask

  initial begin
    int n;
    model_clear();
    reset = 1'b0;
    drive(2'b00, 3'd0, 8'h00, 8'h00, 8'h00);
    set_rd(3'd3, 3'd0);
    repeat (2) @(posedge clk);
    #1;
    push("rst_cnt", 16'h0000);          pop_check(retire_cnt);
    push("rst_rd_a", 16'h0000);         pop_check({8'h00, rd_data_a});
    reset = 1'b1;

    // Preload R3, then assert reset between edges
    write(3'd3, 2'b01, 8'h5A);
    bubble();
    set_rd(3'd3, 3'd3);
    #1;
    push("preload_r3", 16'h005A);       pop_check({8'h00, rd_data_a});
    #1;
    reset = 1'b0;
    model_clear();
    #1;
    push("async_rst_rd", 16'h0000);     pop_check({8'h00, rd_data_a});
    push("async_rst_cnt", 16'h0000);    pop_check(retire_cnt);

    // Write presented while reset is low must be lost
    drive(2'b01, 3'd3, 8'h77, 8'h00, 8'h00);
    #1;
    push("rst_we_comb", 16'h0001);      pop_check({15'h0, wb_we});
    push("rst_data_comb", 16'h0077);    pop_check({8'h00, wb_data});
    push("rst_no_bypass", 16'h0000);    pop_check({8'h00, rd_data_a});
    tick();
    push("rst_blocked", 16'h0000);      pop_check({8'h00, rd_data_a});
    bubble();
    #1;
    reset = 1'b1;
    @(posedge clk);
    #1;

    // Write-back select, destination 5
    drive(2'b01, 3'd5, 8'h12, 8'hAB, 8'hCD);
    #1;
    push("mux01_we", 16'h0001);         pop_check({15'h0, wb_we});
    push("mux01_dest", 16'h0005);       pop_check({13'h0, wb_dest});
    push("mux01_data", 16'h0012);       pop_check({8'h00, wb_data});
    tick();
    bubble();
    set_rd(3'd5, 3'd0);
    #1;
    push("mux01_r5", 16'h0012);         pop_check({8'h00, rd_data_a});
    drive(2'b10, 3'd5, 8'hAA, 8'h34, 8'hCC);
    tick();
    bubble();
    #1;
    push("mux10_r5", 16'h0034);         pop_check({8'h00, rd_data_a});
    drive(2'b11, 3'd5, 8'hAA, 8'hBB, 8'h56);
    tick();
    drive(2'b00, 3'd5, 8'hEE, 8'hEE, 8'hEE);
    #1;
    push("mux00_data", 16'h0000);       pop_check({8'h00, wb_data});
    push("mux00_we", 16'h0000);         pop_check({15'h0, wb_we});
    tick();
    push("mux00_r5", 16'h0056);         pop_check({8'h00, rd_data_a});
    push("mux_cnt", 16'h0003);          pop_check(retire_cnt);

    // R0 guard
    drive(2'b01, 3'd0, 8'hFF, 8'h00, 8'h00);
    set_rd(3'd0, 3'd0);
    #1;
    push("r0_we", 16'h0000);            pop_check({15'h0, wb_we});
    push("r0_rd_a", 16'h0000);          pop_check({8'h00, rd_data_a});
    tick();
    push("r0_rd_after", 16'h0000);      pop_check({8'h00, rd_data_a});
    push("r0_cnt", 16'h0003);           pop_check(retire_cnt);

    // Same-cycle bypass on both ports
    write(3'd2, 2'b01, 8'h11);
    drive(2'b01, 3'd2, 8'h99, 8'h00, 8'h00);
    set_rd(3'd2, 3'd2);
    #1;
    push("byp_a", 16'h0099);            pop_check({8'h00, rd_data_a});
    push("byp_b", 16'h0099);            pop_check({8'h00, rd_data_b});
    tick();
    bubble();
    #1;
    push("byp_arr_a", 16'h0099);        pop_check({8'h00, rd_data_a});
    push("byp_arr_b", 16'h0099);        pop_check({8'h00, rd_data_b});
    push("byp_cnt", ref_cnt);           pop_check(retire_cnt);

    // Counter wrap
    n = 16'hFFFF - int'(ref_cnt);
    for (int i = 0; i < n; i++)
      write(3'(($urandom % 7) + 1), 2'(($urandom % 3) + 1), 8'($urandom));
    bubble();
    #1;
    push("pre_wrap_cnt", 16'hFFFF);     pop_check(retire_cnt);
    push("pre_wrap_r7", {8'h00, ref_regs[7]});
    set_rd(3'd7, 3'd1);
    #1;
    pop_check({8'h00, rd_data_a});
    write(3'd4, 2'b11, 8'h44);
    bubble();
    #1;
    push("wrap_cnt", 16'h0000);         pop_check(retire_cnt);

    // Pipeline stream with a bubble in the middle
    for (int i = 1; i <= 7; i++) begin
      if (i == 4) begin
        bubble();
        tick();
      end
      write(3'(i), 2'((i % 3) + 1), 8'(i));
    end
    bubble();
    for (int i = 1; i <= 7; i++) begin
      set_rd(3'(i), 3'(8 - i));
      #1;
      push($sformatf("stream_a_r%0d", i), 16'(i));
      pop_check({8'h00, rd_data_a});
      push($sformatf("stream_b_r%0d", 8 - i), 16'(8 - i));
      pop_check({8'h00, rd_data_b});
    end
    push("stream_cnt", 16'h0007);       pop_check(retire_cnt);

    $display("%0d/%0d checks passed", pass_cnt, total_cnt);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
# wb_regfile

Write-back stage plus architectural register file for the 8-bit pipelined datapath, sitting directly downstream of the MEM/WB pipeline register. Each cycle it:
- selects the write-back value from the latched memory, ALU and shift results;
- decodes the destination register from the latched 19-bit instruction and commits the write on the clock edge;
- serves two combinational read ports to decode, with same-cycle write-through bypass;
- keeps a retired-write counter for debug and performance observation.

## Interface
Parameters:
- DATA_W, 8, register/data width
- INSTR_W, 19, instruction width
- CNT_W, 16, retired-write counter width

Ports:
- clk  input  1  single clock; all state updates on rising edge
- reset  input  1  asynchronous, active-low; clears all state while low
- wb_mem_data  input  8  memory load result from MEM/WB
- wb_alu_out  input  8  ALU result from MEM/WB
- wb_shift_out  input  8  shifter result from MEM/WB
- wb_instruction  input  19  instruction from MEM/WB
- wb_reg_write_mux  input  2  write-back select from MEM/WB
- rd_addr_a  input  3  read port A address (decode stage)
- rd_addr_b  input  3  read port B address (decode stage)
- rd_data_a  output  8  read port A data (combinational)
- rd_data_b  output  8  read port B data (combinational)
- wb_we  output  1  write enable this cycle (combinational)
- wb_dest  output  3  decoded destination register (combinational)
- wb_data  output  8  selected write-back value (combinational)
- retire_cnt  output  16  number of committed register writes

## Operation
- Destination field: wb_dest = wb_instruction[13:11].
- Write-back select on wb_reg_write_mux:
  - 00: no write; wb_data = 0.
  - 01: wb_alu_out.
  - 10: wb_shift_out.
  - 11: wb_mem_data.
- wb_we = (wb_reg_write_mux != 00) && (wb_dest != 0).
- Register file: R0..R7, 8 bits each.
  - R0 is hardwired zero. A write to R0 is discarded, wb_we stays 0 and retire_cnt does not increment.
- Commit: on rising clk with wb_we=1, R[wb_dest] <= wb_data.
- Read ports: rd_data_x = 0 if rd_addr_x == 0.
  - Otherwise, if wb_we && rd_addr_x == wb_dest, the read returns wb_data (write-through bypass).
  - Otherwise it returns R[rd_addr_x].
  - Ports A and B are independent. Both may read the same register, and both bypass simultaneously when both addresses match.
- retire_cnt increments by 1 on each rising clk where wb_we=1. It wraps from 0xFFFF to 0x0000 with no flag or saturation.
- The block does no hazard detection; stalls and flushes arrive upstream as wb_reg_write_mux=00 (bubble).

## Timing
- Reset (reset=0, asynchronous): R1..R7 = 0, retire_cnt = 0 immediately, independent of clk.
  - While reset is low, writes are blocked and rd_data_a/b read 0 from the cleared file.
  - wb_we/wb_dest/wb_data still follow their inputs combinationally.
- Reset release: first write can commit on the first rising clk after reset goes high.
- Reset asserted mid-operation: any write pending in that cycle is lost; the file is zero.
- Write latency: value visible on read ports in the same cycle through the bypass, and from the register array from the next cycle.
- Read latency: zero cycles (combinational from rd_addr_x, wb_* inputs and array).
- Back-to-back writes to the same register: each cycle's value commits; the last one wins.
- Counter update coincides with the array write edge.

## Test plan
- Reset: preload R3=0x5A, assert reset low between edges. Required: rd_data_a(addr 3)=0x00 and retire_cnt=0 before the next clk edge.
- Mux select, instruction with dest field 5:
  - mux=01, alu=0x12: after the edge, R5=0x12.
  - mux=10, shift=0x34: after the edge, R5=0x34.
  - mux=11, mem=0x56: after the edge, R5=0x56.
  - mux=00: R5 stays 0x56 and retire_cnt=3.
- R0 guard: dest=0, mux=01, alu=0xFF. Required: wb_we=0, rd_data_a(addr 0)=0x00 and retire_cnt unchanged.
- Bypass: R2=0x11, this cycle dest=2, mux=01, alu=0x99, rd_addr_a=rd_addr_b=2. Required: both ports read 0x99 before the edge and the array reads 0x99 after it.
- Counter wrap: force 0xFFFF committed writes, then one more valid write. Required: retire_cnt=0x0000.
- Pipeline stream: writes R1=0x01 … R7=0x07 on consecutive cycles with a bubble (mux=00) in the middle. Required: all seven values readable afterwards and retire_cnt=7.
